irq_controller: RTL and testbench

- Machine-level interrupt controller in front of the CSR file.
- Masks peripheral interrupt lines with the mie register and picks one winner.
- Raises a trap request to the core, supplies the mcause value the CSR file latches on trap entry, acknowledges the served peripheral, and blocks further traps until mret.
- No nesting: one interrupt in service at a time.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_arbiter.sv | 54 +++++
 rtl/irq_controller.sv | 156 +++++++++++++++
 tb/tb_irq_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-level interrupt controller.
// Contents: FSM state enum, mcause/mie field constants, mcause builder.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SERVICE
    } irq_state_t;

    localparam logic [31:0] MCAUSE_INT_BIT  = 32'h8000_0000;
    localparam int          MCAUSE_IRQ_BASE = 16;
    localparam int          MIE_IRQ_LSB     = 16;

    // Wide enough for up to 16 lines.
    localparam int          IRQ_IDX_W       = 4;

    function automatic logic [31:0] irq_mcause(input logic [IRQ_IDX_W-1:0] idx);
        return MCAUSE_INT_BIT | 32'(MCAUSE_IRQ_BASE + int'(idx));
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner selection over the masked interrupt vector.
// Build option: IRQ_ROUND_ROBIN_EN selects round-robin search starting at
// ptr_i (wrapping modulo IRQ_NUM); otherwise lowest index wins and ptr_i
// is unused.
// Ports:
//   masked_i  masked request vector (bit i = line i)
//   ptr_i     round-robin start index
//   valid_o   at least one masked request present
//   index_o   winning line index
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int IRQ_NUM = 16
) (
    input  logic [IRQ_NUM-1:0]   masked_i,
    input  logic [IRQ_IDX_W-1:0] ptr_i,
    output logic                 valid_o,
    output logic [IRQ_IDX_W-1:0] index_o
);

`ifdef IRQ_ROUND_ROBIN_EN
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int k = 0; k < IRQ_NUM; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= IRQ_NUM) begin
                j = j - IRQ_NUM;
            end
            if (!valid_o && masked_i[j]) begin
                valid_o = 1'b1;
                index_o = IRQ_IDX_W'(j);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (masked_i[i]) begin
                valid_o = 1'b1;
                index_o = IRQ_IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/irq_controller.sv
// Machine-level interrupt controller: masks peripheral lines with mie,
// picks one winner, requests a trap, supplies mcause, acknowledges the
// served peripheral and blocks further traps until mret. No nesting.
// Build option: IRQ_ROUND_ROBIN_EN enables round-robin arbitration with a
// pointer register; default is fixed lowest-index priority.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-low reset
//   irq_req_i   level-sensitive requests, bit i = line i
//   mie_i       mie CSR, bit 16+i enables line i
//   trap_ack_i  core accepted the trap this cycle
//   mret_i      core retiring mret this cycle
//   irq_o       trap request to core
//   mcause_o    cause value, valid while irq_o=1
//   irq_ack_o   one-hot single-cycle acknowledge to served peripheral
//   busy_o      interrupt pending or in service
//
// state   | meaning
// IDLE    | no interrupt outstanding, sampling masked requests
// PENDING | winner committed, irq_o raised, waiting for trap_ack_i
// SERVICE | handler running, new requests ignored until mret_i
module irq_controller
    import irq_pkg::*;
#(
    parameter int IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               trap_ack_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        mcause_o,
    output logic [IRQ_NUM-1:0] irq_ack_o,
    output logic               busy_o
);

    irq_state_t            state_q, state_d;
    logic                  irq_q, irq_d;
    logic                  busy_q, busy_d;
    logic [31:0]           mcause_q, mcause_d;
    logic [IRQ_NUM-1:0]    ack_q, ack_d;
    logic [IRQ_IDX_W-1:0]  win_q, win_d;
    logic [IRQ_IDX_W-1:0]  ptr;

    logic [IRQ_NUM-1:0]    masked;
    logic                  arb_valid;
    logic [IRQ_IDX_W-1:0]  arb_idx;

    // Only bits 16..16+IRQ_NUM-1 of mie matter; the rest are dropped here.
    logic unused_mie_bits;
    assign unused_mie_bits = ^mie_i;

    always_comb begin
        for (int i = 0; i < IRQ_NUM; i++) begin
            masked[i] = irq_req_i[i] & mie_i[MIE_IRQ_LSB + i];
        end
    end

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IRQ_IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == PENDING && trap_ack_i) begin
            ptr_d = (int'(win_q) + 1 >= IRQ_NUM) ? '0 : win_q + IRQ_IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    irq_arbiter #(
        .IRQ_NUM (IRQ_NUM)
    ) u_arbiter (
        .masked_i (masked),
        .ptr_i    (ptr),
        .valid_o  (arb_valid),
        .index_o  (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        busy_d   = busy_q;
        mcause_d = mcause_q;
        win_d    = win_q;
        ack_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = PENDING;
                    win_d    = arb_idx;
                    mcause_d = irq_mcause(arb_idx);
                    irq_d    = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            PENDING: begin
                if (trap_ack_i) begin
                    state_d = SERVICE;
                    irq_d   = 1'b0;
                    ack_d   = IRQ_NUM'(1) << win_q;
                end
            end
            SERVICE: begin
                if (mret_i) begin
                    state_d  = IDLE;
                    mcause_d = '0;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                irq_d    = 1'b0;
                busy_d   = 1'b0;
                mcause_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
            mcause_q <= '0;
            ack_q    <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
            mcause_q <= mcause_d;
            ack_q    <= ack_d;
            win_q    <= win_d;
        end
    end

    assign irq_o     = irq_q;
    assign busy_o    = busy_q;
    assign mcause_o  = mcause_q;
    assign irq_ack_o = ack_q;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq_req = '0;
    logic [31:0]   mie = '0;
    logic          trap_ack = 1'b0;
    logic          mret = 1'b0;
    logic          irq_o;
    logic [31:0]   mcause_o;
    logic [N-1:0]  irq_ack_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    irq_controller #(.IRQ_NUM(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .irq_req_i  (irq_req),
        .mie_i      (mie),
        .trap_ack_i (trap_ack),
        .mret_i     (mret),
        .irq_o      (irq_o),
        .mcause_o   (mcause_o),
        .irq_ack_o  (irq_ack_o),
        .busy_o     (busy_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one outstanding line (or none), a service flag,
    // and the cause/ack values the rules say must be visible.
    int           m_pend = -1;
    bit           m_serv = 1'b0;
    logic [31:0]  m_mcause = '0;
    logic [N-1:0] m_ack = '0;
    int           m_ptr = 0;

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j;
`ifdef IRQ_ROUND_ROBIN_EN
            j = (m_ptr + k) % N;
`else
            j = k;
`endif
            if (irq_req[j] && mie[16 + j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_pend = -1; m_serv = 1'b0; m_mcause = '0; m_ack = '0; m_ptr = 0;
        end else begin
            m_ack = '0;
            if (m_serv) begin
                if (mret) begin
                    m_serv = 1'b0;
                    m_mcause = '0;
                end
            end else if (m_pend >= 0) begin
                if (trap_ack) begin
                    m_ack  = N'(1) << m_pend;
                    m_ptr  = (m_pend + 1) % N;
                    m_serv = 1'b1;
                    m_pend = -1;
                end
            end else begin
                int w;
                w = pick();
                if (w >= 0) begin
                    m_pend   = w;
                    m_mcause = 32'h8000_0000 | 32'(16 + w);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("irq_o",     {31'b0, irq_o},  {31'b0, m_pend >= 0});
            chk("busy_o",    {31'b0, busy_o}, {31'b0, (m_pend >= 0) || m_serv});
            chk("mcause_o",  mcause_o, m_mcause);
            chk("irq_ack_o", 32'(irq_ack_o), 32'(m_ack));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int served[4];
    int exp_order[4];

    initial begin
`ifdef IRQ_ROUND_ROBIN_EN
        exp_order = '{0, 2, 0, 2};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b1;
        chk("reset irq", {31'b0, irq_o}, 32'd0);
        chk("reset busy", {31'b0, busy_o}, 32'd0);

        // Basic trap round trip on line 0.
        mie = 32'h0001_0000; irq_req = 16'h0003;
        step();
        chk("basic irq", {31'b0, irq_o}, 32'd1);
        chk("basic mcause", mcause_o, 32'h8000_0010);
        trap_ack = 1'b1; step(); trap_ack = 1'b0; irq_req = '0;
        chk("basic ack", 32'(irq_ack_o), 32'd1);
        chk("basic irq drop", {31'b0, irq_o}, 32'd0);
        step();
        chk("ack one cycle", 32'(irq_ack_o), 32'd0);
        mret = 1'b1; step(); mret = 1'b0;
        chk("mret busy", {31'b0, busy_o}, 32'd0);

        // Masking.
        irq_req = 16'h0001; mie = '0;
        repeat (20) step();
        chk("masked irq", {31'b0, irq_o}, 32'd0);
        mie = 32'h0001_0000;
        step();
        chk("unmasked irq", {31'b0, irq_o}, 32'd1);

        // Commit and hold, then no sampling during service.
        irq_req = '0; mie = '0;
        repeat (3) step();
        chk("hold irq", {31'b0, irq_o}, 32'd1);
        chk("hold mcause", mcause_o, 32'h8000_0010);
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        irq_req = 16'h0020; mie = 32'hFFFF_FFFF;
        repeat (3) step();
        chk("service no irq", {31'b0, irq_o}, 32'd0);
        mret = 1'b1; step(); mret = 1'b0;
        chk("post mret gap", {31'b0, irq_o}, 32'd0);
        step();
        chk("line5 mcause", mcause_o, 32'h8000_0015);
        trap_ack = 1'b1; step(); trap_ack = 1'b0; irq_req = '0;
        mret = 1'b1; step(); mret = 1'b0;

        // mret together with a pending request on line 2.
        irq_req = 16'h0004;
        step();
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        step();
        mret = 1'b1; step(); mret = 1'b0;
        chk("simul gap irq", {31'b0, irq_o}, 32'd0);
        step();
        chk("simul irq", {31'b0, irq_o}, 32'd1);
        chk("simul mcause", mcause_o, 32'h8000_0012);

        // Reset wins over trap_ack: no acknowledge.
        trap_ack = 1'b1; rst = 1'b0; step(); trap_ack = 1'b0; rst = 1'b1; irq_req = '0;
        chk("rst ack", 32'(irq_ack_o), 32'd0);
        chk("rst mcause", mcause_o, 32'd0);

        // Reset mid-SERVICE.
        irq_req = 16'h0004; step(); irq_req = '0;
        trap_ack = 1'b1; step(); trap_ack = 1'b0;
        step();
        rst = 1'b0; step(); rst = 1'b1;
        chk("rst svc busy", {31'b0, busy_o}, 32'd0);
        chk("rst svc ack", 32'(irq_ack_o), 32'd0);

        // Arbitration order with lines 0 and 2 held.
        irq_req = 16'h0005; mie = 32'hFFFF_FFFF;
        for (int r = 0; r < 4; r++) begin
            bit got;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                if (irq_o) got = 1'b1;
                else step();
            end
            chk("arb wait", {31'b0, got}, 32'd1);
            served[r] = int'(mcause_o[7:0]) - 16;
            trap_ack = 1'b1; step(); trap_ack = 1'b0;
            mret = 1'b1; step(); mret = 1'b0;
        end
        irq_req = '0;
        for (int r = 0; r < 4; r++) chk("arb order", 32'(served[r]), 32'(exp_order[r]));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) != 0);
            irq_req  = N'($urandom & $urandom);
            mie      = ($urandom_range(0, 3) == 0) ? $urandom : (32'hFFFF_0000 | $urandom);
            trap_ack = ($urandom_range(0, 2) == 0);
            mret     = ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 1'b1; trap_ack = 1'b0; mret = 1'b0; irq_req = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
